// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared constants for the SDRAM command-port arbiter
package sdram_arb_pkg;

  localparam int AW_DEFAULT = 25;

  // Owner encoding as seen on the owner output
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_VID  = 2'd2;

  // Arbiter FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;

endpackage

// File: rtl/arb_priority_sel.sv
// rtl/arb_priority_sel.sv - combinational CPU/video winner selection
module arb_priority_sel #(
  parameter int CPU_MAX_WAIT = 32,
  parameter int VID_BURST    = 4,
  parameter int WW           = 6,
  parameter int SW           = 3
) (
  input  logic          cpu_req,
  input  logic          vid_req,
  input  logic [WW-1:0] cpu_wait,
  input  logic [SW-1:0] vid_streak,
  output logic          grant_cpu,
  output logic          grant_vid
);

  localparam logic [WW-1:0] WAIT_MAX   = WW'(CPU_MAX_WAIT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(VID_BURST);

  logic cpu_override;

  // Video wins by default; a starved CPU or a long video streak hands the port to the CPU
  always_comb begin
    cpu_override = cpu_req && ((cpu_wait >= WAIT_MAX) || (vid_streak >= STREAK_MAX));
    grant_vid    = vid_req && !cpu_override;
    grant_cpu    = cpu_req && !grant_vid;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares the SDRAM controller command port between CPU and video
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW           = AW_DEFAULT,
  parameter int VID_BURST    = 4,
  parameter int CPU_MAX_WAIT = 32,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic          cpu_ready,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic          vid_ready,
  output logic          ctl_req,
  output logic          ctl_rnw,
  output logic [AW-1:0] ctl_addr,
  output logic [7:0]    ctl_din,
  input  logic          ctl_ack,
  input  logic          ctl_ready,
  input  logic          ctl_busy,
  output logic          timeout_err,
  output logic [1:0]    owner
);

  localparam int WW = $clog2(CPU_MAX_WAIT + 1);
  localparam int SW = $clog2(VID_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [WW-1:0] WAIT_MAX   = WW'(CPU_MAX_WAIT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(VID_BURST);
  localparam logic [TW-1:0] WD_LAST    = TW'(TIMEOUT - 1);

  state_t        state;
  logic [WW-1:0] cpu_wait;
  logic [SW-1:0] vid_streak;
  logic [TW-1:0] wd_cnt;

  logic grant_cpu;
  logic grant_vid;
  logic grant_en;
  logic take_cpu;
  logic take_vid;
  logic cpu_owned;

  arb_priority_sel #(
    .CPU_MAX_WAIT (CPU_MAX_WAIT),
    .VID_BURST    (VID_BURST),
    .WW           (WW),
    .SW           (SW)
  ) u_sel (
    .cpu_req    (cpu_req),
    .vid_req    (vid_req),
    .cpu_wait   (cpu_wait),
    .vid_streak (vid_streak),
    .grant_cpu  (grant_cpu),
    .grant_vid  (grant_vid)
  );

  // A grant is only decided in IDLE while the controller is not refreshing
  always_comb begin
    grant_en  = (state == ST_IDLE) && !ctl_busy;
    take_cpu  = grant_en && grant_cpu;
    take_vid  = grant_en && grant_vid;
    cpu_owned = (state != ST_IDLE) && (owner == OWN_CPU);
  end

  // CPU starvation counter: counts cycles a pending CPU request is kept off the port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_wait <= '0;
    end else if (!cpu_req || take_cpu) begin
      cpu_wait <= '0;
    end else if (!cpu_owned && (cpu_wait != WAIT_MAX)) begin
      cpu_wait <= cpu_wait + 1'b1;
    end
  end

  // Video streak counter: consecutive video grants taken while the CPU is waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_streak <= '0;
    end else if (!cpu_req || take_cpu) begin
      vid_streak <= '0;
    end else if (take_vid && (vid_streak != STREAK_MAX)) begin
      vid_streak <= vid_streak + 1'b1;
    end
  end

  // Command FSM with registered controller-side and requester-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ctl_req     <= 1'b0;
      ctl_rnw     <= 1'b1;
      ctl_addr    <= '0;
      ctl_din     <= '0;
      owner       <= OWN_NONE;
      cpu_ack     <= 1'b0;
      cpu_ready   <= 1'b0;
      vid_ack     <= 1'b0;
      vid_ready   <= 1'b0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      cpu_ack   <= 1'b0;
      cpu_ready <= 1'b0;
      vid_ack   <= 1'b0;
      vid_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take_vid) begin
            ctl_req  <= 1'b1;
            ctl_rnw  <= 1'b1;
            ctl_addr <= vid_addr;
            ctl_din  <= '0;
            owner    <= OWN_VID;
            state    <= ST_ISSUE;
          end else if (take_cpu) begin
            ctl_req  <= 1'b1;
            ctl_rnw  <= cpu_rnw;
            ctl_addr <= cpu_addr;
            ctl_din  <= cpu_din;
            owner    <= OWN_CPU;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ctl_ack) begin
            ctl_req <= 1'b0;
            wd_cnt  <= '0;
            cpu_ack <= (owner == OWN_CPU);
            vid_ack <= (owner == OWN_VID);
            if (ctl_ready) begin
              cpu_ready <= (owner == OWN_CPU);
              vid_ready <= (owner == OWN_VID);
              owner     <= OWN_NONE;
              state     <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (ctl_ready) begin
            cpu_ready <= (owner == OWN_CPU);
            vid_ready <= (owner == OWN_VID);
            owner     <= OWN_NONE;
            state     <= ST_IDLE;
          end else if (wd_cnt == WD_LAST) begin
            // Controller never finished: drop the transaction, the requester retries
            timeout_err <= 1'b1;
            owner       <= OWN_NONE;
            state       <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  localparam int AW = 25;

  logic          clk;
  logic          reset;
  logic          cpu_req;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_ack;
  logic          cpu_ready;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic          vid_ready;
  logic          ctl_req;
  logic          ctl_rnw;
  logic [AW-1:0] ctl_addr;
  logic [7:0]    ctl_din;
  logic          ctl_ack;
  logic          ctl_ready;
  logic          ctl_busy;
  logic          timeout_err;
  logic [1:0]    owner;

  logic m_ack, m_ready, f_ack, f_ready;
  assign ctl_ack   = m_ack | f_ack;
  assign ctl_ready = m_ready | f_ready;

  int ack_dly;
  int rdy_dly;
  bit never_ready;
  bit ctl_en;

  int n_checks;
  int n_fail;

  sdram_port_arbiter #(
    .AW           (AW),
    .VID_BURST    (4),
    .CPU_MAX_WAIT (32),
    .TIMEOUT      (255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_rnw     (cpu_rnw),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_ack     (cpu_ack),
    .cpu_ready   (cpu_ready),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_ack     (vid_ack),
    .vid_ready   (vid_ready),
    .ctl_req     (ctl_req),
    .ctl_rnw     (ctl_rnw),
    .ctl_addr    (ctl_addr),
    .ctl_din     (ctl_din),
    .ctl_ack     (ctl_ack),
    .ctl_ready   (ctl_ready),
    .ctl_busy    (ctl_busy),
    .timeout_err (timeout_err),
    .owner       (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Controller model: acks ack_dly cycles after seeing ctl_req, readies rdy_dly cycles after ack
  initial begin
    m_ack   = 1'b0;
    m_ready = 1'b0;
    forever begin
      tick();
      if (ctl_en && ctl_req) begin
        repeat (ack_dly) tick();
        m_ack = 1'b1;
        if (rdy_dly == 0 && !never_ready) m_ready = 1'b1;
        tick();
        m_ack   = 1'b0;
        m_ready = 1'b0;
        if (rdy_dly > 0 && !never_ready) begin
          repeat (rdy_dly - 1) tick();
          m_ready = 1'b1;
          tick();
          m_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic          c_req;
    logic          c_rnw;
    logic [AW-1:0] c_addr;
    logic [7:0]    c_din;
    logic          v_req;
    logic [AW-1:0] v_addr;
    int            a_dly;
    int            r_dly;
    logic [1:0]    e_owner;
    logic          e_rnw;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_din;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int acks, readys, wrong, ack_at, rdy_at, vcnt, ncpu, bad, seen, rdy_i, cpu_at;
    int counts[2];

    vecs[0] = '{1'b1, 1'b0, 25'h0001234, 8'hA5, 1'b0, 25'h0000000, 3, 5, 2'd1, 1'b0, 25'h0001234, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 25'h1FFFFFF, 8'h3C, 1'b0, 25'h0000000, 2, 3, 2'd1, 1'b1, 25'h1FFFFFF, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 25'h0000000, 8'h00, 1'b1, 25'h00ABCDE, 1, 2, 2'd2, 1'b1, 25'h00ABCDE, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 25'h0000055, 8'h77, 1'b1, 25'h0000777, 2, 2, 2'd2, 1'b1, 25'h0000777, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 25'h0000000, 8'hFF, 1'b0, 25'h0000000, 2, 0, 2'd1, 1'b0, 25'h0000000, 8'hFF};
    vecs[5] = '{1'b0, 1'b1, 25'h0000000, 8'h00, 1'b1, 25'h1000001, 1, 1, 2'd2, 1'b1, 25'h1000001, 8'h00};

    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_din = '0;
    vid_req = 1'b0; vid_addr = '0;
    ctl_busy = 1'b0; f_ack = 1'b0; f_ready = 1'b0;
    ack_dly = 1; rdy_dly = 1; never_ready = 1'b0; ctl_en = 1'b1;

    tick(); tick();
    check("reset_ctl_req", 32'(ctl_req), 32'd0);
    check("reset_ctl_rnw", 32'(ctl_rnw), 32'd1);
    check("reset_owner", 32'(owner), 32'd0);
    check("reset_timeout_err", 32'(timeout_err), 32'd0);
    check("reset_pulses", 32'(cpu_ack | cpu_ready | vid_ack | vid_ready), 32'd0);
    reset = 1'b0;
    tick(); tick();

    // Table-driven single transactions
    for (int k = 0; k < 6; k++) begin
      ack_dly = vecs[k].a_dly;
      rdy_dly = vecs[k].r_dly;
      cpu_req = vecs[k].c_req; cpu_rnw = vecs[k].c_rnw;
      cpu_addr = vecs[k].c_addr; cpu_din = vecs[k].c_din;
      vid_req = vecs[k].v_req; vid_addr = vecs[k].v_addr;
      tick();
      check($sformatf("v%0d_ctl_req", k), 32'(ctl_req), 32'd1);
      check($sformatf("v%0d_owner", k), 32'(owner), 32'(vecs[k].e_owner));
      check($sformatf("v%0d_ctl_rnw", k), 32'(ctl_rnw), 32'(vecs[k].e_rnw));
      check($sformatf("v%0d_ctl_addr", k), 32'(ctl_addr), 32'(vecs[k].e_addr));
      check($sformatf("v%0d_ctl_din", k), 32'(ctl_din), 32'(vecs[k].e_din));
      acks = 0; readys = 0; wrong = 0; ack_at = -1; rdy_at = -1;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (vecs[k].e_owner == 2'd1) begin
          if (cpu_ack) begin acks++; ack_at = i; cpu_req = 1'b0; vid_req = 1'b0; end
          if (cpu_ready) begin readys++; rdy_at = i; end
          if (vid_ack || vid_ready) wrong++;
        end else begin
          if (vid_ack) begin acks++; ack_at = i; cpu_req = 1'b0; vid_req = 1'b0; end
          if (vid_ready) begin readys++; rdy_at = i; end
          if (cpu_ack || cpu_ready) wrong++;
        end
      end
      check($sformatf("v%0d_ack_count", k), 32'(acks), 32'd1);
      check($sformatf("v%0d_ready_count", k), 32'(readys), 32'd1);
      check($sformatf("v%0d_other_pulses", k), 32'(wrong), 32'd0);
      check($sformatf("v%0d_ack_latency", k), 32'(ack_at), 32'(vecs[k].a_dly + 1));
      check($sformatf("v%0d_ready_after_ack", k), 32'(rdy_at - ack_at), 32'(vecs[k].r_dly));
      check($sformatf("v%0d_owner_end", k), 32'(owner), 32'd0);
    end

    // Video first, then CPU granted in the IDLE cycle right after vid_ready
    ack_dly = 1; rdy_dly = 2;
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 25'h42; cpu_din = 8'h11;
    vid_req = 1'b1; vid_addr = 25'h100;
    tick();
    check("b2b_first_owner", 32'(owner), 32'd2);
    rdy_i = -1; cpu_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (vid_ack) vid_req = 1'b0;
      if (cpu_ack) cpu_req = 1'b0;
      if (vid_ready && rdy_i < 0) rdy_i = i;
      if (ctl_req && owner == 2'd1 && cpu_at < 0) cpu_at = i;
    end
    check("b2b_vid_ready_seen", 32'(rdy_i > 0), 32'd1);
    check("b2b_cpu_grant_cycle", 32'(cpu_at - rdy_i), 32'd1);
    check("b2b_cpu_addr", 32'(ctl_addr), 32'h42);

    // Continuous video with pending CPU: CPU every VID_BURST video grants
    ack_dly = 1; rdy_dly = 2;
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 25'h9; vid_req = 1'b1; vid_addr = 25'h200;
    vcnt = 0; ncpu = 0;
    for (int i = 0; i < 400 && ncpu < 2; i++) begin
      tick();
      if (vid_ack) vcnt++;
      if (cpu_ack) begin counts[ncpu] = vcnt; ncpu++; vcnt = 0; end
    end
    check("streak_cpu_grants_seen", 32'(ncpu), 32'd2);
    if (ncpu == 2) begin
      check("streak_first_vid_count", 32'(counts[0]), 32'd4);
      check("streak_second_vid_count", 32'(counts[1]), 32'd4);
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    repeat (20) tick();

    // ctl_busy blocks grants; CPU wins once cpu_wait has saturated
    ctl_busy = 1'b1;
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 25'h77; cpu_din = 8'h5A;
    vid_req = 1'b1; vid_addr = 25'h300;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ctl_req) bad++;
    end
    check("busy_no_ctl_req", 32'(bad), 32'd0);
    ctl_busy = 1'b0;
    tick();
    check("busy_release_ctl_req", 32'(ctl_req), 32'd1);
    check("busy_release_owner_cpu", 32'(owner), 32'd1);
    cpu_req = 1'b0; vid_req = 1'b0;
    repeat (20) tick();

    // Unsolicited ack/ready in IDLE are ignored
    f_ack = 1'b1; f_ready = 1'b1;
    tick();
    f_ack = 1'b0; f_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_ack || cpu_ready || vid_ack || vid_ready || ctl_req || owner != 2'd0) bad++;
    end
    check("unsolicited_ignored", 32'(bad), 32'd0);

    // Watchdog: ack without ready
    never_ready = 1'b1; ack_dly = 1;
    vid_req = 1'b1; vid_addr = 25'h3;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      if (vid_ack) seen = 1;
    end
    check("wd_vid_ack_seen", 32'(seen), 32'd1);
    vid_req = 1'b0;
    bad = 0;
    for (int i = 1; i <= 254; i++) begin
      tick();
      if (vid_ready || cpu_ready) bad++;
    end
    check("wd_err_before_expiry", 32'(timeout_err), 32'd0);
    tick();
    if (vid_ready || cpu_ready) bad++;
    check("wd_err_at_expiry", 32'(timeout_err), 32'd1);
    check("wd_owner_cleared", 32'(owner), 32'd0);
    check("wd_no_ready", 32'(bad), 32'd0);
    never_ready = 1'b0; ack_dly = 1; rdy_dly = 2;
    vid_req = 1'b1; vid_addr = 25'h44;
    tick();
    check("wd_next_owner", 32'(owner), 32'd2);
    check("wd_next_addr", 32'(ctl_addr), 32'h44);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (vid_ack) vid_req = 1'b0;
      if (vid_ready) seen++;
    end
    check("wd_next_ready", 32'(seen), 32'd1);
    check("wd_err_sticky", 32'(timeout_err), 32'd1);

    // Asynchronous reset mid-WAIT
    never_ready = 1'b1;
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 25'h99; cpu_din = 8'h12;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      if (cpu_ack) seen = 1;
    end
    check("rst_cpu_ack_seen", 32'(seen), 32'd1);
    cpu_req = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("rst_async_owner", 32'(owner), 32'd0);
    check("rst_async_ctl_rnw", 32'(ctl_rnw), 32'd1);
    check("rst_async_ctl_addr", 32'(ctl_addr), 32'd0);
    check("rst_async_ctl_din", 32'(ctl_din), 32'd0);
    check("rst_async_timeout_err", 32'(timeout_err), 32'd0);
    tick();
    reset = 1'b0;
    never_ready = 1'b0;
    tick();
    vid_req = 1'b1; vid_addr = 25'h5;
    tick();
    check("rst_after_owner", 32'(owner), 32'd2);
    check("rst_after_ctl_req", 32'(ctl_req), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vid_ack) vid_req = 1'b0;
    end
    check("rst_after_idle", 32'(owner), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
